// File: rtl/mlp_stream_harness.sv
// Sequential harness around a combinational MLP classifier.
// Feature beats arrive over a valid/ready stream and are packed into dut_inp.
// The packed vector is held for SETTLE_CYCLES before dut_out is captured.
// The captured class is compared with the golden label and returned over a
// valid/ready result stream. Saturating counters track delivered results and
// the results whose class did not match the label.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_LOAD   | accepting feature beats into slot idx of dut_inp
// ST_SETTLE | vector frozen, settle counter running down to capture
// ST_OUT    | result presented on m_*, waiting for m_ready
module mlp_stream_harness #(
  parameter int NUM_A         = 4,
  parameter int WIDTH_A       = 4,
  parameter int OUTWIDTH      = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH_A-1:0]       s_data,
  input  logic [OUTWIDTH-1:0]      s_label,
  output logic [NUM_A*WIDTH_A-1:0] dut_inp,
  input  logic [OUTWIDTH-1:0]      dut_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUTWIDTH-1:0]      m_class,
  output logic                     m_match,
  input  logic                     clear,
  output logic [CNT_W-1:0]         vec_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  // A width of at least one bit keeps NUM_A==1 and SETTLE_CYCLES==1 legal.
  localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_A - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t                     state_q,   state_d;
  logic [IDX_W-1:0]           idx_q,     idx_d;
  logic [SET_W-1:0]           settle_q,  settle_d;
  logic [NUM_A*WIDTH_A-1:0]   dut_inp_q, dut_inp_d;
  logic [OUTWIDTH-1:0]        label_q,   label_d;
  logic [OUTWIDTH-1:0]        m_class_q, m_class_d;
  logic                       m_match_q, m_match_d;
  logic                       m_valid_q, m_valid_d;
  logic [CNT_W-1:0]           vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]           err_cnt_q, err_cnt_d;

  // Next-state, datapath and counter update; every _d defaults to hold.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    dut_inp_d = dut_inp_q;
    label_d   = label_q;
    m_class_d = m_class_q;
    m_match_d = m_match_q;
    m_valid_d = m_valid_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          dut_inp_d[int'(idx_q)*WIDTH_A +: WIDTH_A] = s_data;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            label_d  = s_label;
            settle_d = SET_LOAD;
            state_d  = ST_SETTLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_q == '0) begin
          m_class_d = dut_out;
          m_match_d = (dut_out == label_q);
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_LOAD;
          if (vec_cnt_q != CNT_MAX) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
          end
          if (!m_match_q && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Clear overrides a same-edge handshake increment.
    if (clear) begin
      vec_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  // State, datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      idx_q     <= '0;
      settle_q  <= '0;
      dut_inp_q <= '0;
      label_q   <= '0;
      m_class_q <= '0;
      m_match_q <= 1'b0;
      m_valid_q <= 1'b0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      dut_inp_q <= dut_inp_d;
      label_q   <= label_d;
      m_class_q <= m_class_d;
      m_match_q <= m_match_d;
      m_valid_q <= m_valid_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_ready = (state_q == ST_LOAD);
  assign dut_inp = dut_inp_q;
  assign m_valid = m_valid_q;
  assign m_class = m_class_q;
  assign m_match = m_match_q;
  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule
